// File: rtl/trig_series_unit.sv
// Iterative fixed-point Taylor-series evaluator for cos(x) / sin(x).
// One shared multiplier is time-multiplexed across the LOAD, MUL and SCALE
// states; the series coefficients are elaboration-time constants.
module trig_series_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 11,
  parameter int unsigned TERMS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result
);

  localparam int unsigned KW = $clog2(TERMS);

  localparam logic signed [WIDTH-1:0]   MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] MAX2 = {{WIDTH{1'b0}}, MAXV};
  localparam logic signed [2*WIDTH-1:0] MIN2 = {{WIDTH{1'b1}}, MINV};
  // Round-half-up bias added before the arithmetic shift.
  localparam logic signed [2*WIDTH-1:0] RND  = (2*WIDTH)'(64'sd1 <<< (FRAC - 1));
  localparam longint                    MAXL = (64'sd1 <<< (WIDTH - 1)) - 1;
  // 1.0 in the working format, clamped if the format cannot represent it.
  localparam logic signed [WIDTH-1:0]   ONE  =
      (FRAC >= WIDTH - 1) ? MAXV : WIDTH'(64'sd1 <<< FRAC);

  localparam logic [KW-1:0] KLAST = KW'(TERMS - 1);

  // round(2^FRAC / (d1*d2)); floor((floor(2N/d) + 1) / 2) is round-half-up.
  function automatic longint calc_coef(input bit sine, input int k);
    longint d;
    longint q;
    if (k == 0) return 0;
    d = sine ? longint'(2 * k) * longint'(2 * k + 1)
             : longint'(2 * k - 1) * longint'(2 * k);
    q = (((64'sd1 <<< (FRAC + 1)) / d) + 1) / 2;
    if (q > MAXL) q = MAXL;
    return q;
  endfunction

  // Full-precision signed product, rounded and saturated back to WIDTH.
  function automatic logic signed [WIDTH-1:0] mul_round(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    logic signed [2*WIDTH-1:0] s;
    p = a * b;
    p = p + RND;
    s = p >>> FRAC;
    if (s > MAX2) return MAXV;
    if (s < MIN2) return MINV;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] a);
    return (a == MINV) ? MAXV : -a;
  endfunction

  function automatic logic signed [WIDTH-1:0] add_sat(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? MINV : MAXV;
    return s[WIDTH-1:0];
  endfunction

  // Coefficient tables; entry 0 is never used by the loop.
  logic signed [WIDTH-1:0] coef_cos [TERMS];
  logic signed [WIDTH-1:0] coef_sin [TERMS];

  for (genvar g = 0; g < TERMS; g++) begin : g_coef
    localparam longint CC = calc_coef(1'b0, g);
    localparam longint CS = calc_coef(1'b1, g);
    assign coef_cos[g] = WIDTH'(CC);
    assign coef_sin[g] = WIDTH'(CS);
  end

  typedef enum logic [2:0] {StIdle, StLoad, StMul, StScale, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic signed [WIDTH-1:0] x2_q, x2_d;
  logic signed [WIDTH-1:0] term_q, term_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic [KW-1:0]           k_q, k_d;

  logic signed [WIDTH-1:0] mul_a, mul_b, mul_p;
  logic signed [WIDTH-1:0] coef_k;

  // Operand select for the single shared multiplier.
  always_comb begin
    coef_k = mode_q ? coef_sin[k_q] : coef_cos[k_q];
    mul_a  = x_q;
    mul_b  = x_q;
    unique case (state_q)
      StMul:   begin mul_a = term_q; mul_b = x2_q;   end
      StScale: begin mul_a = term_q; mul_b = coef_k; end
      default: begin mul_a = x_q;    mul_b = x_q;    end
    endcase
    mul_p = mul_round(mul_a, mul_b);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    x_d      = x_q;
    x2_d     = x2_q;
    term_d   = term_q;
    acc_d    = acc_q;
    result_d = result_q;
    k_d      = k_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = x_in;
          mode_d  = mode;
          state_d = StLoad;
        end
      end
      StLoad: begin
        x2_d    = mul_p;
        term_d  = mode_q ? x_q : ONE;
        acc_d   = term_d;
        k_d     = KW'(1);
        state_d = StMul;
      end
      StMul: begin
        term_d  = mul_p;
        state_d = StScale;
      end
      StScale: begin
        // Alternating series: each new term is the negated scaled product.
        term_d = neg_sat(mul_p);
        acc_d  = add_sat(acc_q, term_d);
        if (k_q == KLAST) begin
          result_d = acc_d;
          state_d  = StDone;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = StMul;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      mode_q   <= 1'b0;
      x_q      <= '0;
      x2_q     <= '0;
      term_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      x_q      <= x_d;
      x2_q     <= x2_d;
      term_q   <= term_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      k_q      <= k_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_trig_series_unit.sv
// Self-checking bench for trig_series_unit against an arithmetic series model.
module tb_trig_series_unit;

  localparam int     WIDTH = 16;
  localparam int     FRAC  = 11;
  localparam int     TERMS = 6;
  localparam int     LAT   = 2 * TERMS - 1;
  localparam longint MAXV  = 32767;
  localparam longint MINV  = -32768;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic                    mode = 1'b0;
  logic signed [WIDTH-1:0] x_in = '0;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trig_series_unit #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .TERMS (TERMS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .x_in   (x_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain saturating fixed-point arithmetic on integers.
  function automatic longint sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint fx_mul(input longint a, input longint b);
    return sat((a * b + (64'sd1 <<< (FRAC - 1))) >>> FRAC);
  endfunction

  function automatic longint coef(input bit sine, input int k);
    int d;
    d = sine ? (2 * k) * (2 * k + 1) : (2 * k - 1) * (2 * k);
    return longint'($rtoi($floor(real'(64'sd1 <<< FRAC) / real'(d) + 0.5)));
  endfunction

  function automatic longint series(input longint x, input bit sine);
    longint x2;
    longint term;
    longint acc;
    x2   = fx_mul(x, x);
    term = sine ? x : (64'sd1 <<< FRAC);
    acc  = term;
    for (int k = 1; k < TERMS; k++) begin
      term = fx_mul(term, x2);
      term = sat(-fx_mul(term, coef(sine, k)));
      acc  = sat(acc + term);
    end
    return acc;
  endfunction

  function automatic bit near(input longint v, input longint target);
    return (v >= target - 2) && (v <= target + 2);
  endfunction

  // Wait (bounded) for done; lat counts edges after acceptance, -1 on timeout.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  // One edge after done the block must be back in IDLE.
  task automatic to_idle(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_idle_busy"}, longint'(busy), 0);
    check({tag, "_idle_done"}, longint'(done), 0);
  endtask

  task automatic run_op(input logic signed [WIDTH-1:0] x, input logic m,
                        output longint res, output int lat, output int bcnt);
    @(negedge clk);
    x_in  = x;
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("accept_busy", longint'(busy), 1);
    wait_done(lat, bcnt);
    check("busy_at_done", longint'(busy), 1);
    check("result_known", longint'($isunknown(result)), 0);
    res = longint'(result);
  endtask

  longint res;
  int     lat;
  int     bcnt;
  int     acc_b;
  logic signed [WIDTH-1:0] rx;
  logic                    rm;

  initial begin
    // Reset state.
    #1;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_result", longint'(result), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // cos(0): exact 1.0, fixed latency and busy window.
    run_op(16'sh0000, 1'b0, res, lat, bcnt);
    check("cos0_latency", lat, LAT);
    check("cos0_busy_cycles", bcnt, LAT + 1);
    check("cos0_result", res, 2048);
    to_idle("cos0");

    // cos(0.5), sin(0.5), cos(1.0) against tolerance and exact model.
    run_op(16'sh0400, 1'b0, res, lat, bcnt);
    check("cos05_latency", lat, LAT);
    check("cos05_near_1797", longint'(near(res, 1797)), 1);
    check("cos05_model", res, series(1024, 1'b0));
    to_idle("cos05");

    run_op(16'sh0400, 1'b1, res, lat, bcnt);
    check("sin05_near_982", longint'(near(res, 982)), 1);
    check("sin05_model", res, series(1024, 1'b1));
    to_idle("sin05");

    run_op(16'sh0800, 1'b0, res, lat, bcnt);
    check("cos1_near_1107", longint'(near(res, 1107)), 1);
    check("cos1_model", res, series(2048, 1'b0));
    to_idle("cos1");

    // Busy lockout: start held, x_in changed mid-run.
    @(negedge clk);
    x_in  = 16'sh0400;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("lock_accept", longint'(busy), 1);
    repeat (4) @(posedge clk);
    #1;
    x_in = 16'sh0800;
    mode = 1'b1;
    wait_done(lat, bcnt);
    check("lock_latency", lat, LAT - 4);
    check("lock_near_1797", longint'(near(longint'(result), 1797)), 1);
    @(posedge clk);
    #1;
    check("lock_idle_gap", longint'(busy), 0);
    @(posedge clk);
    #1;
    check("lock_second_accept", longint'(busy), 1);
    mode  = 1'b0;
    start = 1'b0;
    wait_done(lat, bcnt);
    check("lock_second_latency", lat, LAT);
    // Second op captured x_in=0x0800 with mode=1 at its accepting edge.
    check("lock_second_model", longint'(result), series(2048, 1'b1));
    to_idle("lock2");

    // Saturation: out-of-range angle, timing unchanged.
    run_op(16'sh7FFF, 1'b0, res, lat, bcnt);
    check("sat_latency", lat, LAT);
    check("sat_model", res, series(32767, 1'b0));
    to_idle("sat");

    // Randomised operations against the model.
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) rx = WIDTH'($urandom_range(0, 4096) - 2048);
      else            rx = WIDTH'($urandom);
      rm = 1'($urandom % 2);
      run_op(rx, rm, res, lat, bcnt);
      check("rand_latency", lat, LAT);
      check("rand_model", res, series(longint'(rx), rm));
      to_idle("rand");
    end

    // Asynchronous reset mid-computation aborts and clears.
    @(negedge clk);
    x_in  = 16'sh0400;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_result", longint'(result), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    acc_b = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      acc_b += int'(busy) + int'(done);
    end
    check("abort_stays_idle", acc_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trig_series_unit.md
Name: trig_series_unit

Overview:
- Parametrised successor to the fixed-point cosine control-unit/datapath pair.
- Evaluates cos(x) or sin(x) by a truncated Taylor series in signed fixed point, with configurable width, fraction bits and term count.
- Uses an iterative multiply–scale–accumulate loop behind a start/done handshake.
- Single instance is driven by a higher-level controller; one computation is in flight at a time.

Parameters:
- WIDTH, 16: total data width, signed two's complement.
- FRAC, 11: fraction bits (default format Q5.11).
- TERMS, 6: number of series terms including the constant/linear term; legal range 2..8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = cosine, 1 = sine; captured with start.
- x_in  input  WIDTH  signed angle in radians, Q(WIDTH-FRAC).FRAC; captured with start.
- busy  output  1  high from accepting edge until the DONE state is left.
- done  output  1  single-cycle pulse; result is valid.
- result  output  WIDTH  signed series sum; holds until the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, result=0; all internal registers = 0. Asserting reset mid-computation aborts immediately; no done is produced.
- States:
  - IDLE: start=1 captures x, mode → LOAD; busy=1 from this edge.
  - LOAD (1 cycle): x2 = x*x; term = 1.0 (cos) or x (sin); acc = term; k = 1 → MUL.
  - MUL (1 cycle): term = term*x2 → SCALE.
  - SCALE (1 cycle): term = -(term*C[k]); acc = acc + term; if k == TERMS-1 → DONE, else k = k+1 → MUL.
  - DONE (1 cycle): result = acc; done=1 → IDLE. busy=1 during DONE and drops on the edge leaving it.
- Latency: done is high in the cycle after edge 2*TERMS-1, counting the accepting edge as 0. For TERMS=6, that is edge 11.
- Throughput: a new start is accepted in the IDLE cycle immediately after DONE, i.e. back-to-back operations with a 1-cycle IDLE gap.
- start while busy: ignored, no queuing. x_in and mode changes while busy have no effect.
- Coefficients: C[k] = round(2^FRAC / (d1*d2)).
  - Cosine: d1 = 2k-1, d2 = 2k.
  - Sine: d1 = 2k, d2 = 2k+1.
  - Coefficients are generated from parameters at elaboration; no runtime division.
  - Values for FRAC=11: cos C1..C3 = 1024, 171, 68; sin C1..C2 = 341, 102.
- Multiply: full 2*WIDTH signed product, add 2^(FRAC-1), arithmetic shift right by FRAC (round half up), then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Accumulate: saturating add at WIDTH bits; the sign of term is negated before the add.
- Negation of the most-negative value saturates to max positive.
- Accuracy: within ±2 LSB of the true value for |x| <= 1.0 at defaults. Outside [-pi, pi] the result is a truncated series with saturation, and no accuracy is guaranteed.
- done and start asserted in the same cycle: start is ignored, because the state is DONE, not IDLE.

Test Plan:
- Reset: rst=0 for 2 cycles during an active LOAD/MUL → busy=0, done=0, result=0x0000 immediately. After release with start=0, the block stays IDLE.
- cos(0): x_in=0x0000, mode=0, start for 1 cycle → done pulses exactly 11 edges after acceptance. result=0x0800 (1.0), busy high for 12 cycles.
- cos(0.5): x_in=0x0400, mode=0 → result 1797±2 (0x0705±2).
- sin(0.5): x_in=0x0400, mode=1 → result 982±2. Then cos(1.0) with x_in=0x0800, mode=0 → result 1107±2.
- Busy lockout: start held high throughout the cos(0.5) run with x_in toggled to 0x0800 mid-run → result 1797±2. A second operation starts on the IDLE cycle after done.
- Saturation: x_in=0x7FFF, mode=0 → no X/overflow wrap; every intermediate and the result stay within [0x8000, 0x7FFF]; done timing unchanged.
